// File: rtl/vga_pkg.sv
// Shared pixel types and defaults for the VGA output path.
package vga_pkg;
  localparam int PIXEL_W    = 12;
  localparam int CH_W       = PIXEL_W / 3;
  localparam int MAX_LAYERS = 8;
  localparam logic [PIXEL_W-1:0] KEY_COLOR = 12'h000;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

  typedef struct packed {
    logic [MAX_LAYERS-1:0] en;
    logic [MAX_LAYERS-1:0] blend;
  } layer_cfg_t;

  // Per-channel truncating average; the extra carry bit keeps the sum exact.
  function automatic rgb_t rgb_avg(rgb_t a, rgb_t b);
    logic [CH_W:0] sr, sg, sb;
    rgb_t res;
    sr = {1'b0, a.r} + {1'b0, b.r};
    sg = {1'b0, a.g} + {1'b0, b.g};
    sb = {1'b0, a.b} + {1'b0, b.b};
    res.r = sr[CH_W:1];
    res.g = sg[CH_W:1];
    res.b = sb[CH_W:1];
    return res;
  endfunction
endpackage

// File: rtl/layer_compositor_sync_delay.sv
// Fixed-depth register delay line for sync/control bits with a per-bit reset value.
module sync_delay #(
  parameter int               WIDTH   = 4,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out
);
  logic [WIDTH-1:0] pipe_q [DEPTH];
  logic [WIDTH-1:0] pipe_d [DEPTH];

  always_comb begin
    pipe_d[0] = d_in;
    for (int k = 1; k < DEPTH; k++) pipe_d[k] = pipe_q[k-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) pipe_q[k] <= RST_VAL;
    end else begin
      for (int k = 0; k < DEPTH; k++) pipe_q[k] <= pipe_d[k];
    end
  end

  assign q_out = pipe_q[DEPTH-1];
endmodule

// File: rtl/layer_compositor.sv
// N-layer colour-keyed pixel compositor with optional 50% blend and frame-synchronous config.
module layer_compositor
  import vga_pkg::*;
#(
  parameter int                 NUM_LAYERS = 4,
  parameter int                 PIXEL_W    = vga_pkg::PIXEL_W,
  parameter logic [PIXEL_W-1:0] KEY_COLOR  = vga_pkg::KEY_COLOR
) (
  input  logic                          clk_pixel_in,
  input  logic                          rst_n_in,
  input  logic [NUM_LAYERS*PIXEL_W-1:0] layers_in,
  input  logic                          hsync_in,
  input  logic                          vsync_in,
  input  logic                          blank_in,
  input  logic                          frame_start_in,
  input  logic                          cfg_valid_in,
  input  logic [NUM_LAYERS-1:0]         cfg_en_in,
  input  logic [NUM_LAYERS-1:0]         cfg_blend_in,
  output logic                          cfg_ready_out,
  output logic [PIXEL_W-1:0]            pixel_out,
  output logic                          hsync_out,
  output logic                          vsync_out,
  output logic                          blank_out
);
  localparam int CH_W = PIXEL_W / 3;

  function automatic logic [PIXEL_W-1:0] avg_px(input logic [PIXEL_W-1:0] a,
                                                input logic [PIXEL_W-1:0] b);
    logic [PIXEL_W-1:0] r;
    logic [CH_W:0]      s;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      s = {1'b0, a[c*CH_W +: CH_W]} + {1'b0, b[c*CH_W +: CH_W]};
      r[c*CH_W +: CH_W] = s[CH_W:1];
    end
    return r;
  endfunction

  logic [NUM_LAYERS*PIXEL_W-1:0] layers_p1_q, layers_p1_d;
  logic hsync_p1, vsync_p1, blank_p1, fs_p1;
  logic [NUM_LAYERS-1:0] act_en_q, act_en_d, act_blend_q, act_blend_d;
  logic [NUM_LAYERS-1:0] pend_en_q, pend_en_d, pend_blend_q, pend_blend_d;
  logic pend_full_q, pend_full_d, cfg_ready_q, cfg_ready_d;
  logic [PIXEL_W-1:0] pixel_q, pixel_d;
  logic [NUM_LAYERS-1:0] eff_en, eff_blend;
  logic [PIXEL_W-1:0] acc, li;
  logic apply;

  // Stage 1: register pixels and control
  sync_delay #(.WIDTH(4), .DEPTH(1), .RST_VAL(4'b0010)) u_sync_p1 (
    .clk   (clk_pixel_in),
    .rst_n (rst_n_in),
    .d_in  ({hsync_in, vsync_in, blank_in, frame_start_in}),
    .q_out ({hsync_p1, vsync_p1, blank_p1, fs_p1})
  );

  // Stage 2: composite and register outputs
  sync_delay #(.WIDTH(3), .DEPTH(1), .RST_VAL(3'b001)) u_sync_p2 (
    .clk   (clk_pixel_in),
    .rst_n (rst_n_in),
    .d_in  ({hsync_p1, vsync_p1, blank_p1}),
    .q_out ({hsync_out, vsync_out, blank_out})
  );

  always_comb begin
    layers_p1_d = layers_in;
    // A pending config lands on the frame_start pixel itself, so bypass it into this composite.
    apply     = fs_p1 && pend_full_q;
    eff_en    = apply ? pend_en_q    : act_en_q;
    eff_blend = apply ? pend_blend_q : act_blend_q;
    acc = layers_p1_q[PIXEL_W-1:0];
    li  = '0;
    for (int i = 1; i < NUM_LAYERS; i++) begin
      li = layers_p1_q[i*PIXEL_W +: PIXEL_W];
      if (eff_en[i] && (li != KEY_COLOR)) acc = eff_blend[i] ? avg_px(acc, li) : li;
    end
    pixel_d = blank_p1 ? '0 : acc;
  end

  always_comb begin
    act_en_d     = act_en_q;
    act_blend_d  = act_blend_q;
    pend_en_d    = pend_en_q;
    pend_blend_d = pend_blend_q;
    pend_full_d  = pend_full_q;
    if (apply) begin
      act_en_d    = pend_en_q;
      act_blend_d = pend_blend_q;
      pend_full_d = 1'b0;
    end
    // Accept and apply are exclusive: accept needs the slot empty, apply needs it full.
    if (cfg_valid_in && cfg_ready_q) begin
      pend_en_d    = cfg_en_in;
      pend_blend_d = cfg_blend_in;
      pend_full_d  = 1'b1;
    end
    cfg_ready_d = !pend_full_d;
  end

  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      layers_p1_q  <= '0;
      pixel_q      <= '0;
      act_en_q     <= '1;
      act_blend_q  <= '0;
      pend_en_q    <= '0;
      pend_blend_q <= '0;
      pend_full_q  <= 1'b0;
      cfg_ready_q  <= 1'b1;
    end else begin
      layers_p1_q  <= layers_p1_d;
      pixel_q      <= pixel_d;
      act_en_q     <= act_en_d;
      act_blend_q  <= act_blend_d;
      pend_en_q    <= pend_en_d;
      pend_blend_q <= pend_blend_d;
      pend_full_q  <= pend_full_d;
      cfg_ready_q  <= cfg_ready_d;
    end
  end

  assign pixel_out     = pixel_q;
  assign cfg_ready_out = cfg_ready_q;
endmodule

// File: tb/tb_layer_compositor.sv
// Bench for layer_compositor: directed table, corner sequences and randomized run vs reference model.
module tb_layer_compositor;
  localparam int NL = 4;
  localparam int PW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [NL*PW-1:0] layers;
  logic hs, vs, bl, fs, cv;
  logic [NL-1:0] cen, cbl;
  logic cfg_ready_out, hsync_out, vsync_out, blank_out;
  logic [PW-1:0] pixel_out;

  layer_compositor #(.NUM_LAYERS(NL), .PIXEL_W(PW), .KEY_COLOR(12'h000)) dut (
    .clk_pixel_in   (clk),
    .rst_n_in       (rst_n),
    .layers_in      (layers),
    .hsync_in       (hs),
    .vsync_in       (vs),
    .blank_in       (bl),
    .frame_start_in (fs),
    .cfg_valid_in   (cv),
    .cfg_en_in      (cen),
    .cfg_blend_in   (cbl),
    .cfg_ready_out  (cfg_ready_out),
    .pixel_out      (pixel_out),
    .hsync_out      (hsync_out),
    .vsync_out      (vsync_out),
    .blank_out      (blank_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: the pixel sampled one edge ago, active/pending config, expected outputs.
  logic [NL*PW-1:0] m1_lay;
  logic m1_hs, m1_vs, m1_bl, m1_fs;
  logic [3:0] m_act_en, m_act_bl, m_pen_en, m_pen_bl;
  bit m_full, e_rdy, chk_model;
  logic [11:0] e_pix;
  logic e_hs, e_vs, e_bl;

  function automatic logic [11:0] ref_pix(input logic [47:0] lay, input logic [3:0] en,
                                          input logic [3:0] bm, input logic blank);
    int r, g, b, pr, pg, pb;
    logic [11:0] p;
    p = lay[11:0];
    r = int'(p[11:8]); g = int'(p[7:4]); b = int'(p[3:0]);
    for (int i = 1; i < 4; i++) begin
      p = lay[i*12 +: 12];
      if (en[i] && p != 12'h000) begin
        pr = int'(p[11:8]); pg = int'(p[7:4]); pb = int'(p[3:0]);
        if (bm[i]) begin
          r = (r + pr) / 2; g = (g + pg) / 2; b = (b + pb) / 2;
        end else begin
          r = pr; g = pg; b = pb;
        end
      end
    end
    if (blank) return 12'h000;
    return {r[3:0], g[3:0], b[3:0]};
  endfunction

  task automatic model_reset();
    e_pix = 12'h000; e_hs = 1'b0; e_vs = 1'b0; e_bl = 1'b1; e_rdy = 1'b1;
    m_act_en = 4'hF; m_act_bl = 4'h0; m_pen_en = 4'h0; m_pen_bl = 4'h0; m_full = 1'b0;
    m1_lay = '0; m1_hs = 1'b0; m1_vs = 1'b0; m1_bl = 1'b1; m1_fs = 1'b0;
  endtask

  task automatic model_edge();
    logic [3:0] en_u, bl_u;
    if (m1_fs && m_full) begin
      m_act_en = m_pen_en; m_act_bl = m_pen_bl; m_full = 1'b0;
    end
    en_u = m_act_en; bl_u = m_act_bl;
    e_pix = ref_pix(m1_lay, en_u, bl_u, m1_bl);
    e_hs = m1_hs; e_vs = m1_vs; e_bl = m1_bl;
    if (cv && e_rdy) begin
      m_pen_en = cen; m_pen_bl = cbl; m_full = 1'b1;
    end
    e_rdy = !m_full;
    m1_lay = layers; m1_hs = hs; m1_vs = vs; m1_bl = bl; m1_fs = fs;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    if (chk_model) begin
      chk("model_pixel", pixel_out, e_pix);
      chk("model_hsync", hsync_out, e_hs);
      chk("model_vsync", vsync_out, e_vs);
      chk("model_blank", blank_out, e_bl);
      chk("model_ready", cfg_ready_out, e_rdy);
    end
  endtask

  task automatic set_lay(input logic [11:0] l0, l1, l2, l3);
    layers = {l3, l2, l1, l0};
  endtask

  task automatic offer_cfg(input logic [3:0] en, input logic [3:0] bm);
    int n;
    n = 0;
    while (!cfg_ready_out && n < 64) begin
      cyc();
      n++;
    end
    if (!cfg_ready_out) chk("cfg_ready_timeout", cfg_ready_out, 1);
    cv = 1'b1; cen = en; cbl = bm;
    cyc();
    cv = 1'b0;
  endtask

  typedef struct {
    logic [11:0] l0, l1, l2, l3;
    logic [3:0]  en, bm;
    logic [11:0] exp;
  } vec_t;
  vec_t tbl[10];

  initial begin
    tbl[0] = '{12'h123, 12'h000, 12'h000, 12'h000, 4'hF, 4'h0, 12'h123};
    tbl[1] = '{12'h123, 12'hF00, 12'h0F0, 12'h000, 4'hF, 4'h0, 12'h0F0};
    tbl[2] = '{12'h0F0, 12'hF00, 12'h000, 12'h000, 4'hF, 4'h2, 12'h770};
    tbl[3] = '{12'hFFF, 12'hFFE, 12'h000, 12'h000, 4'hF, 4'h2, 12'hFFE};
    tbl[4] = '{12'hABC, 12'h111, 12'h222, 12'h333, 4'hF, 4'h0, 12'h333};
    tbl[5] = '{12'hABC, 12'h111, 12'h222, 12'h333, 4'h5, 4'h0, 12'h222};
    tbl[6] = '{12'hABC, 12'h111, 12'h222, 12'h333, 4'h1, 4'h0, 12'hABC};
    tbl[7] = '{12'h000, 12'h000, 12'h888, 12'h444, 4'hF, 4'h8, 12'h666};
    tbl[8] = '{12'hFFF, 12'h000, 12'hF00, 12'h00F, 4'hF, 4'hC, 12'h73B};
    tbl[9] = '{12'h5A5, 12'h000, 12'h000, 12'h000, 4'hE, 4'h0, 12'h5A5};

    rst_n = 1'b0; layers = '0; hs = 0; vs = 0; bl = 1; fs = 0; cv = 0; cen = '0; cbl = '0;
    chk_model = 1'b0;
    model_reset();
    #12;
    chk("rst_pixel", pixel_out, 12'h000);
    chk("rst_blank", blank_out, 1);
    chk("rst_hsync", hsync_out, 0);
    chk("rst_ready", cfg_ready_out, 1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    chk_model = 1'b1;
    cyc(); cyc();

    // Two-cycle latency of pixel and syncs
    set_lay(12'h123, 12'h000, 12'h000, 12'h000); bl = 0; hs = 1; vs = 1;
    cyc();
    chk("lat_pixel_t1", pixel_out, 12'h000);
    chk("lat_hsync_t1", hsync_out, 0);
    hs = 0; vs = 0;
    cyc();
    chk("lat_pixel_t2", pixel_out, 12'h123);
    chk("lat_hsync_t2", hsync_out, 1);
    chk("lat_vsync_t2", vsync_out, 1);
    cyc();
    chk("lat_hsync_t3", hsync_out, 0);

    foreach (tbl[k]) begin
      offer_cfg(tbl[k].en, tbl[k].bm);
      set_lay(tbl[k].l0, tbl[k].l1, tbl[k].l2, tbl[k].l3); fs = 1;
      cyc();
      fs = 0;
      cyc();
      chk($sformatf("tbl%0d_pixel", k), pixel_out, tbl[k].exp);
    end

    // Mid-frame offer: held until the next frame_start pixel
    offer_cfg(4'hF, 4'h0);
    set_lay(12'hABC, 12'h111, 12'h222, 12'h333); fs = 1;
    cyc(); fs = 0; cyc(); cyc();
    chk("mid_pre", pixel_out, 12'h333);
    cv = 1; cen = 4'b0001; cbl = 4'h0;
    cyc(); cv = 0;
    chk("mid_ready_drop", cfg_ready_out, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("mid_still_visible", pixel_out, 12'h333);
    end
    fs = 1; cyc(); fs = 0; cyc();
    chk("mid_applied", pixel_out, 12'hABC);
    chk("mid_ready_back", cfg_ready_out, 1);

    // Offer coinciding with stage-1 frame_start: deferred a whole frame
    fs = 1; cyc();
    fs = 0; cv = 1; cen = 4'hF; cbl = 4'h0;
    cyc(); cv = 0;
    chk("same_fs_pixel_old", pixel_out, 12'hABC);
    cyc(); cyc();
    chk("same_frame_old", pixel_out, 12'hABC);
    chk("same_ready_low", cfg_ready_out, 0);
    fs = 1; cyc(); fs = 0; cyc();
    chk("same_next_frame", pixel_out, 12'h333);

    // Reset mid-line with a pending config that must be discarded
    offer_cfg(4'b0001, 4'h0);
    cyc();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mrst_pixel", pixel_out, 12'h000);
    chk("mrst_blank", blank_out, 1);
    chk("mrst_ready", cfg_ready_out, 1);
    cyc();
    #2 rst_n = 1'b1;
    bl = 0;
    cyc();
    chk("mrst_post_blank1", blank_out, 1);
    cyc();
    chk("mrst_post_pixel", pixel_out, 12'h333);
    fs = 1; cyc(); fs = 0; cyc();
    chk("mrst_pending_gone", pixel_out, 12'h333);

    // Randomized run checked against the model every cycle
    for (int n = 0; n < 800; n++) begin
      int col;
      col = n % 20;
      fs = (n % 60) == 0;
      bl = col >= 16;
      hs = col == 17;
      vs = (n % 60) < 3;
      for (int i = 0; i < NL; i++)
        layers[i*PW +: PW] = ($urandom_range(0, 2) == 0) ? 12'h000 : 12'($urandom);
      cv  = $urandom_range(0, 5) == 0;
      cen = 4'($urandom);
      cbl = 4'($urandom);
      cyc();
    end
    cv = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
